// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer slice: FSM state encoding,
// program-counter width and the reset PC value.
package pc_seq_pkg;

  localparam int unsigned PC_W = 16;
  localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_ISSUE   = 3'd2,
    S_RESOLVE = 3'd3,
    S_HALT    = 3'd4
  } state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: sequential increment (modulo 2^16),
// branch/jump target, and, when PC_SEQ_IRQ_EN is defined, the IRQ vector.
// Ports:
//   instr_pc   PC of the instruction being resolved
//   br_taken   redirect requested
//   br_target  redirect target
//   irq_take   (PC_SEQ_IRQ_EN) divert to IRQ_VECTOR
//   resume_pc  (PC_SEQ_IRQ_EN) PC the program would have continued at
//   next_pc    value to write into the PC register
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_INC     = 16'd2
`ifdef PC_SEQ_IRQ_EN
  , parameter logic [PC_W-1:0] IRQ_VECTOR = 16'h0010
`endif
) (
  input  logic [PC_W-1:0] instr_pc,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
`ifdef PC_SEQ_IRQ_EN
  input  logic            irq_take,
  output logic [PC_W-1:0] resume_pc,
`endif
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] flow_pc;

  always_comb begin
    flow_pc = br_taken ? br_target : instr_pc + PC_INC;
`ifdef PC_SEQ_IRQ_EN
    resume_pc = flow_pc;
    next_pc   = irq_take ? IRQ_VECTOR : flow_pc;
`else
    next_pc   = flow_pc;
`endif
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/issue/resolve controller for the 16-bit program counter.
// Fetches at the current PC, hands the instruction to the core, waits for
// execute completion and issues exactly one PC write per instruction.
// Optional feature macro: PC_SEQ_IRQ_EN (adds irq, irq_ack, epc, IRQ_VECTOR).
// Ports:
//   clk, rst (sync, active-low)
//   pc_cur          current PC register value
//   wrPC, dataIn    one-cycle PC write pulse and value
//   imem_req/addr   fetch request; imem_ack/imem_data fetch response
//   instr_valid/out/pc, instr_ready   instruction handoff to the core
//   exec_done, br_taken, br_target, halt   completion info from the core
//   halted, fetch_err   status (fetch_err is sticky until reset)
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_INC      = 16'd2,
  parameter int unsigned     ACK_TIMEOUT = 15
`ifdef PC_SEQ_IRQ_EN
  , parameter logic [PC_W-1:0] IRQ_VECTOR = 16'h0010
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc_cur,
  output logic            wrPC,
  output logic [PC_W-1:0] dataIn,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [PC_W-1:0] imem_data,
  output logic            instr_valid,
  output logic [PC_W-1:0] instr_out,
  output logic [PC_W-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            exec_done,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            halt,
`ifdef PC_SEQ_IRQ_EN
  input  logic            irq,
  output logic            irq_ack,
  output logic [PC_W-1:0] epc,
`endif
  output logic            halted,
  output logic            fetch_err
);

  localparam logic [7:0] ACK_TO = 8'(ACK_TIMEOUT);

  state_t          state, state_nx;
  logic [7:0]      cnt, cnt_nx, cnt_inc;
  logic            wr_nx, req_nx, valid_nx, halted_nx, err_nx;
  logic [PC_W-1:0] din_nx, addr_nx, iout_nx, ipc_nx, next_pc;
`ifdef PC_SEQ_IRQ_EN
  logic            irq_take, irq_ack_nx;
  logic [PC_W-1:0] resume_pc, epc_nx;

  assign irq_take = irq && !halt;
`endif

  pc_next_sel #(
    .PC_INC     (PC_INC)
`ifdef PC_SEQ_IRQ_EN
    , .IRQ_VECTOR (IRQ_VECTOR)
`endif
  ) u_next_sel (
    .instr_pc  (instr_pc),
    .br_taken  (br_taken),
    .br_target (br_target),
`ifdef PC_SEQ_IRQ_EN
    .irq_take  (irq_take),
    .resume_pc (resume_pc),
`endif
    .next_pc   (next_pc)
  );

  assign cnt_inc = cnt + 8'd1;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    wr_nx     = 1'b0;
    din_nx    = dataIn;
    req_nx    = imem_req;
    addr_nx   = imem_addr;
    valid_nx  = instr_valid;
    iout_nx   = instr_out;
    ipc_nx    = instr_pc;
    halted_nx = halted;
    err_nx    = fetch_err;
`ifdef PC_SEQ_IRQ_EN
    irq_ack_nx = 1'b0;
    epc_nx     = epc;
`endif
    unique case (state)
      S_IDLE: begin
        state_nx = S_FETCH;
        req_nx   = 1'b1;
        addr_nx  = pc_cur;
        cnt_nx   = '0;
      end
      S_FETCH: begin
        if (imem_ack) begin
          iout_nx  = imem_data;
          ipc_nx   = imem_addr;
          req_nx   = 1'b0;
          valid_nx = 1'b1;
          state_nx = S_ISSUE;
        end else if (cnt_inc == ACK_TO) begin
          cnt_nx    = cnt_inc;
          err_nx    = 1'b1;
          req_nx    = 1'b0;
          halted_nx = 1'b1;
          state_nx  = S_HALT;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          valid_nx = 1'b0;
          state_nx = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        if (exec_done) begin
          wr_nx  = 1'b1;
          din_nx = next_pc;
`ifdef PC_SEQ_IRQ_EN
          irq_ack_nx = irq_take;
          if (irq_take) epc_nx = resume_pc;
`endif
          if (halt) begin
            halted_nx = 1'b1;
            state_nx  = S_HALT;
          end else begin
            // The PC register only takes the write one edge later, so the
            // fetch address is loaded with the value being written; this is
            // exactly what pc_cur will hold once the write lands.
            req_nx   = 1'b1;
            addr_nx  = next_pc;
            cnt_nx   = '0;
            state_nx = S_FETCH;
          end
        end
      end
      S_HALT: begin
        halted_nx = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      wrPC        <= 1'b0;
      dataIn      <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= RESET_PC;
      halted      <= 1'b0;
      fetch_err   <= 1'b0;
`ifdef PC_SEQ_IRQ_EN
      irq_ack     <= 1'b0;
      epc         <= '0;
`endif
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      wrPC        <= wr_nx;
      dataIn      <= din_nx;
      imem_req    <= req_nx;
      imem_addr   <= addr_nx;
      instr_valid <= valid_nx;
      instr_out   <= iout_nx;
      instr_pc    <= ipc_nx;
      halted      <= halted_nx;
      fetch_err   <= err_nx;
`ifdef PC_SEQ_IRQ_EN
      irq_ack     <= irq_ack_nx;
      epc         <= epc_nx;
`endif
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed transactions with literal
// expectations plus a transaction-level model compared every cycle.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_reg;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic        wrPC;
  logic [15:0] dataIn;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        instr_valid;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        exec_done;
  logic        br_taken;
  logic [15:0] br_target;
  logic        halt;
  logic        halted;
  logic        fetch_err;
`ifdef PC_SEQ_IRQ_EN
  logic        irq_ack;
  logic [15:0] epc;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_INC(16'd2), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_reg),
    .wrPC(wrPC), .dataIn(dataIn),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .exec_done(exec_done),
    .br_taken(br_taken), .br_target(br_target), .halt(halt),
`ifdef PC_SEQ_IRQ_EN
    .irq(1'b0), .irq_ack(irq_ack), .epc(epc),
`endif
    .halted(halted), .fetch_err(fetch_err)
  );

  // PC register owned by the bench: takes wrPC writes, or a direct load.
  always @(posedge clk) begin
    if (pc_load) pc_reg <= pc_load_val;
    else if (wrPC) pc_reg <= dataIn;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: where the instruction flow is (idle, fetching,
  // offered to core, executing, stopped) and the values each step produces.
  int          m_phase;      // 0 idle, 1 fetching, 2 offered, 3 executing, 4 stopped
  int          m_wait;
  bit          m_ready = 0;
  bit          m_wr;
  bit          m_err;
  int          m_din;
  int          m_fetch_pc;
  logic [15:0] m_instr;
  int          m_ipc;

  always @(negedge clk) begin
    if (m_ready) begin
      check("wrPC", wrPC, m_wr);
      if (m_wr) check("dataIn", dataIn, m_din);
      check("imem_req", imem_req, m_phase == 1);
      if (m_phase == 1) check("imem_addr", imem_addr, m_fetch_pc);
      check("instr_valid", instr_valid, m_phase == 2);
      if (m_phase == 2) begin
        check("instr_out", instr_out, m_instr);
        check("instr_pc", instr_pc, m_ipc);
      end
      check("halted", halted, m_phase == 4);
      check("fetch_err", fetch_err, m_err);
    end
    m_wr = 0;
    if (rst !== 1'b1) begin
      m_phase = 0; m_wait = 0; m_err = 0; m_ready = 1;
    end else begin
      case (m_phase)
        0: begin m_phase = 1; m_wait = 0; m_fetch_pc = pc_reg; end
        1: begin
          if (imem_ack) begin
            m_instr = imem_data; m_ipc = m_fetch_pc; m_phase = 2;
          end else begin
            m_wait++;
            if (m_wait == 15) begin m_phase = 4; m_err = 1; end
          end
        end
        2: if (instr_ready) m_phase = 3;
        3: if (exec_done) begin
          m_wr  = 1;
          m_din = br_taken ? int'(br_target) : (m_ipc + 2) % 65536;
          if (halt) m_phase = 4;
          else begin m_phase = 1; m_wait = 0; m_fetch_pc = m_din; end
        end
        default: ;
      endcase
    end
  end

  task automatic tick(input int unsigned n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [15:0] pc);
    rst = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; exec_done = 1'b0;
    br_taken = 1'b0; halt = 1'b0;
    pc_load = 1'b1; pc_load_val = pc;
    tick(2);
    pc_load = 1'b0;
    check("rst wrPC", wrPC, 0);
    check("rst dataIn", dataIn, 0);
    check("rst imem_req", imem_req, 0);
    check("rst imem_addr", imem_addr, 0);
    check("rst instr_valid", instr_valid, 0);
    check("rst instr_out", instr_out, 0);
    check("rst instr_pc", instr_pc, 0);
    check("rst halted", halted, 0);
    check("rst fetch_err", fetch_err, 0);
    rst = 1'b1;
  endtask

  task automatic fetch(input int unsigned dly, input logic [15:0] data, input logic [15:0] exp_addr);
    int unsigned k = 0;
    while (imem_req !== 1'b1 && k < 50) begin tick(1); k++; end
    check("wait imem_req", imem_req, 1);
    check("fetch addr", imem_addr, exp_addr);
    tick(dly);
    imem_ack = 1'b1; imem_data = data;
    tick(1);
    imem_ack = 1'b0;
    check("req drop after ack", imem_req, 0);
  endtask

  task automatic issue(input logic [15:0] exp_instr, input logic [15:0] exp_pc);
    int unsigned k = 0;
    while (instr_valid !== 1'b1 && k < 50) begin tick(1); k++; end
    check("wait instr_valid", instr_valid, 1);
    check("issued instr", instr_out, exp_instr);
    check("issued pc", instr_pc, exp_pc);
    instr_ready = 1'b1;
    tick(1);
    instr_ready = 1'b0;
    check("valid drop", instr_valid, 0);
  endtask

  task automatic resolve(input int unsigned dly, input logic br, input logic [15:0] tgt,
                         input logic h, input logic [15:0] exp);
    tick(dly);
    exec_done = 1'b1; br_taken = br; br_target = tgt; halt = h;
    tick(1);
    exec_done = 1'b0; br_taken = 1'b0; halt = 1'b0;
    check("wrPC pulse", wrPC, 1);
    check("write value", dataIn, exp);
  endtask

  initial begin
    rst = 1'b0; pc_load = 1'b0; pc_load_val = '0; imem_ack = 1'b0; imem_data = '0;
    instr_ready = 1'b0; exec_done = 1'b0; br_taken = 1'b0; br_target = '0; halt = 1'b0;
    tick(1);

    // Sequential step from 0x0000
    do_reset(16'h0000);
    fetch(2, 16'h1234, 16'h0000);
    issue(16'h1234, 16'h0000);
    resolve(1, 1'b0, 16'h0000, 1'b0, 16'h0002);

    // Taken branch
    fetch(0, 16'hABCD, 16'h0002);
    issue(16'hABCD, 16'h0002);
    resolve(0, 1'b1, 16'h0040, 1'b0, 16'h0040);

    // Completion info while fetching is ignored
    exec_done = 1'b1; br_taken = 1'b1; br_target = 16'h7777;
    fetch(3, 16'h5A5A, 16'h0040);
    exec_done = 1'b0; br_taken = 1'b0;
    issue(16'h5A5A, 16'h0040);
    resolve(2, 1'b0, 16'h0000, 1'b0, 16'h0042);

    // Sequential wrap at the top of the address space
    do_reset(16'hFFFE);
    fetch(0, 16'h0F0F, 16'hFFFE);
    issue(16'h0F0F, 16'hFFFE);
    resolve(0, 1'b0, 16'h0000, 1'b0, 16'h0000);

    // Ack on the 15th waiting cycle wins over the timeout
    fetch(14, 16'h1111, 16'h0000);
    check("late ack no err", fetch_err, 0);
    issue(16'h1111, 16'h0000);
    resolve(0, 1'b0, 16'h0000, 1'b0, 16'h0002);

    // No ack at all: timeout
    fetch_wait_timeout();

    // Halt with exec_done: write still happens, then stopped
    do_reset(16'h0010);
    fetch(1, 16'h5555, 16'h0010);
    issue(16'h5555, 16'h0010);
    resolve(0, 1'b0, 16'h0000, 1'b1, 16'h0012);
    check("halted after halt", halted, 1);
    for (int i = 0; i < 8; i++) begin
      exec_done = i[0];
      tick(1);
      check("halt no req", imem_req, 0);
      check("halt no write", wrPC, 0);
    end
    exec_done = 1'b0;

    // Reset in the middle of execution, with exec_done in the same cycle
    do_reset(16'h0200);
    fetch(0, 16'h2222, 16'h0200);
    issue(16'h2222, 16'h0200);
    rst = 1'b0; exec_done = 1'b1;
    tick(1);
    exec_done = 1'b0;
    check("mid rst wrPC", wrPC, 0);
    check("mid rst instr_out", instr_out, 0);
    check("mid rst instr_pc", instr_pc, 0);
    check("mid rst dataIn", dataIn, 0);
    // Stale ack arriving right after reset must be ignored
    rst = 1'b1; imem_ack = 1'b1; imem_data = 16'hDEAD;
    tick(1);
    imem_ack = 1'b0;
    fetch(1, 16'h3333, 16'h0200);
    issue(16'h3333, 16'h0200);
    resolve(0, 1'b0, 16'h0000, 1'b0, 16'h0202);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic fetch_wait_timeout();
    int unsigned k = 0;
    while (imem_req !== 1'b1 && k < 50) begin tick(1); k++; end
    check("wait imem_req", imem_req, 1);
    check("timeout fetch addr", imem_addr, 16'h0002);
    tick(14);
    check("req before timeout", imem_req, 1);
    check("no err before timeout", fetch_err, 0);
    tick(1);
    check("timeout err", fetch_err, 1);
    check("timeout halted", halted, 1);
    check("timeout req", imem_req, 0);
    tick(4);
    check("timeout sticky", fetch_err, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
